mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipeline's instruction-fetch port (IF) and load/store port (LS).
- Sits between the pipelined core's fetch/MEM stages and the memory macro.
- Serialises accesses, times the fixed memory read latency, and returns the response to the owning requester.
- Strict LS-over-IF priority by default; an optional fairness guard bounds IF starvation.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MEM_LAT, 2, cycles from the o_mem_en cycle to valid i_mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive LS grants allowed while IF waits; used only with the optional feature

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-low reset
- i_if_req  in  1  fetch request; held with stable i_if_addr until o_if_gnt
- i_if_addr  in  ADDR_W  fetch address
- o_if_gnt  out  1  fetch request accepted, one-cycle pulse
- o_if_rvalid  out  1  fetch data valid, one-cycle pulse
- o_if_rdata  out  DATA_W  fetch data
- i_ls_req  in  1  load/store request; held with stable fields until o_ls_gnt
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  ADDR_W  load/store address
- i_ls_wdata  in  DATA_W  store data
- i_ls_bmask  in  DATA_W/8  store byte enables
- o_ls_gnt  out  1  load/store request accepted, one-cycle pulse
- o_ls_rvalid  out  1  load data valid, or store completion, one-cycle pulse
- o_ls_rdata  out  DATA_W  load data
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  DATA_W/8  memory byte enables
- i_mem_rdata  in  DATA_W  memory read data
- o_busy  out  1  state is not IDLE

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE; all outputs 0; owner and latency counter cleared.
  - Any in-flight access is abandoned with no rvalid.
  - Release is synchronous to i_clk.
- States:
  - IDLE: arbitration.
  - ISSUE: o_mem_en=1 for exactly one cycle.
  - WAIT: counts MEM_LAT cycles.
  - RESP: rvalid to the owner for one cycle.
- IDLE:
  - If any request is pending, the winner's gnt is asserted combinationally in that cycle.
  - Winner's fields (LS: addr/we/wdata/bmask; IF: addr with we=0 and bmask all-ones) are registered; owner is recorded; next state is ISSUE.
  - No request: stay in IDLE.
- Priority: LS wins if i_ls_req=1; otherwise IF wins. Simultaneous requests grant LS only, and IF stays pending.
- ISSUE: o_mem_en=1 and o_mem_addr/we/wdata/bmask come from the registers. Counter loads MEM_LAT-1. Next state is WAIT, or RESP directly if MEM_LAT=1.
- WAIT: counter decrements each cycle; at 0, next state is RESP.
- RESP (MEM_LAT cycles after the ISSUE cycle):
  - Owner's rvalid=1 for one cycle.
  - For a read, owner's rdata = i_mem_rdata, passed through combinationally in that cycle only.
  - For a store, rdata=0.
  - Next state is IDLE.
  - The non-owner's rvalid/rdata are 0 at all times.
- o_mem_en=0 outside ISSUE; the o_mem_* fields keep their registered values.
- Throughput: one access per MEM_LAT+2 cycles; grant-to-rvalid latency is MEM_LAT+1 cycles.
- Requests asserted outside IDLE are ignored until IDLE; no grant is given outside IDLE.
- A request dropped before its gnt is legal and has no effect.

Optional Feature:
- Macro MEM_ARB_FAIRNESS_EN.
- Defined:
  - A starvation counter increments on each LS grant made while i_if_req=1.
  - It clears on any IF grant, and on any LS grant made while i_if_req=0.
  - When the counter equals STARVE_MAX and both requests are pending, IF wins.
- Undefined: strict LS priority and no counter logic.

Test Plan:
- Reset, then a single IF read at 0x0000_0010 with memory returning 0x0000_0013 -> o_if_gnt in cycle 0, o_mem_en in cycle 1, o_if_rvalid=1 with o_if_rdata=0x0000_0013 in cycle 3 (MEM_LAT=2), o_busy=0 in cycle 4.
- LS store to 0x0000_7000 with wdata=0xDEADBEEF and bmask=4'b0011 -> one o_mem_en cycle with o_mem_we=1 and matching fields; o_ls_rvalid pulse with rdata=0; o_if_rvalid stays 0.
- IF and LS requests in the same cycle (load 0x100 and fetch 0x200) -> LS granted first, IF granted in the next IDLE cycle four cycles later; each gets only its own rdata.
- Continuous LS requests with IF pending:
  - Without the macro, IF is never granted over 20 transactions.
  - With MEM_ARB_FAIRNESS_EN and STARVE_MAX=4, IF is granted after exactly 4 LS grants.
- i_reset pulled low during WAIT of an LS load -> all outputs 0 immediately and no o_ls_rvalid; after release, a new IF request is served normally.
- MEM_LAT=1 build -> ISSUE goes directly to RESP; rvalid follows gnt by 2 cycles; back-to-back IF reads every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch (IF) and load/store (LS) ports.
// Optional IF starvation guard is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_bmask,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       owner_ls;
    logic [3:0] lat_cnt;
    logic       arb_ok;
    logic       pick_ls;
    logic       resp_ls;
    logic       resp_if;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    // Once LS has won STARVE_MAX times in a row over a waiting IF, IF takes the next slot.
    assign pick_ls = i_ls_req && !(i_if_req && (starve_cnt == SC_W'(STARVE_MAX)));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            starve_cnt <= '0;
        end else if (o_ls_gnt) begin
            starve_cnt <= i_if_req ? starve_cnt + 1'b1 : '0;
        end else if (o_if_gnt) begin
            starve_cnt <= '0;
        end
    end
`else
    assign pick_ls = i_ls_req;
`endif

    // Grants are combinational and suppressed while reset is held so every output reads 0.
    assign arb_ok   = (state == IDLE) && i_reset;
    assign o_ls_gnt = arb_ok && pick_ls;
    assign o_if_gnt = arb_ok && !pick_ls && i_if_req;

    assign resp_ls     = (state == RESP) && owner_ls;
    assign resp_if     = (state == RESP) && !owner_ls;
    assign o_ls_rvalid = resp_ls;
    assign o_ls_rdata  = (resp_ls && !o_mem_we) ? i_mem_rdata : '0;
    assign o_if_rvalid = resp_if;
    assign o_if_rdata  = resp_if ? i_mem_rdata : '0;
    assign o_busy      = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            owner_ls    <= 1'b0;
            lat_cnt     <= '0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (o_ls_gnt) begin
                        o_mem_we    <= i_ls_we;
                        o_mem_addr  <= i_ls_addr;
                        o_mem_wdata <= i_ls_wdata;
                        o_mem_bmask <= i_ls_bmask;
                        owner_ls    <= 1'b1;
                        o_mem_en    <= 1'b1;
                        state       <= ISSUE;
                    end else if (o_if_gnt) begin
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= i_if_addr;
                        o_mem_bmask <= '1;
                        owner_ls    <= 1'b0;
                        o_mem_en    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_mem_en <= 1'b0;
                    lat_cnt  <= 4'(MEM_LAT - 1);
                    state    <= (MEM_LAT == 1) ? RESP : WAIT;
                end
                // Counter reaches zero on the cycle read data becomes valid.
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=2 instance and a MEM_LAT=1 instance,
// each behind a memory model that returns addr+3 exactly MEM_LAT cycles after o_mem_en.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_bmask;

    logic        if1_req, if1_gnt, if1_rvalid, ls1_gnt, ls1_rvalid, mem1_en, mem1_we, busy1;
    logic [31:0] if1_addr, if1_rdata, ls1_rdata, mem1_addr, mem1_wdata, mem1_rdata;
    logic [3:0]  mem1_bmask;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask), .o_ls_gnt(ls_gnt),
        .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if1_req), .i_if_addr(if1_addr), .o_if_gnt(if1_gnt),
        .o_if_rvalid(if1_rvalid), .o_if_rdata(if1_rdata),
        .i_ls_req(1'b0), .i_ls_we(1'b0), .i_ls_addr(32'h0),
        .i_ls_wdata(32'h0), .i_ls_bmask(4'h0), .o_ls_gnt(ls1_gnt),
        .o_ls_rvalid(ls1_rvalid), .o_ls_rdata(ls1_rdata),
        .o_mem_en(mem1_en), .o_mem_we(mem1_we), .o_mem_addr(mem1_addr),
        .o_mem_wdata(mem1_wdata), .o_mem_bmask(mem1_bmask),
        .i_mem_rdata(mem1_rdata), .o_busy(busy1)
    );

    // Memory models: data is only meaningful in the latency slot, garbage otherwise.
    logic        e1, e2, f1;
    logic [31:0] a1, a2, b1;
    always @(posedge clk) begin
        e1 <= mem_en;  a1 <= mem_addr;
        e2 <= e1;      a2 <= a1;
        f1 <= mem1_en; b1 <= mem1_addr;
    end
    assign mem_rdata  = e2 ? a2 + 32'd3 : 32'hBAD0_BAD0;
    assign mem1_rdata = f1 ? b1 + 32'd3 : 32'hBAD1_BAD1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] addrs [3];
    int ls_cnt, if_cnt, ls_before_if;

    initial begin
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0; ls_bmask = 0;
        if1_req = 0; if1_addr = 0;
        addrs[0] = 32'h1000; addrs[1] = 32'h2000; addrs[2] = 32'h3000;

        // Reset state
        repeat (3) tick();
        smp();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        tick(); rst = 1;

        // Single IF read
        tick(); if_req = 1; if_addr = 32'h10;
        smp();
        chk("if_gnt_c0", 64'(if_gnt), 64'd1);
        chk("ls_gnt_c0", 64'(ls_gnt), 64'd0);
        chk("busy_c0", 64'(busy), 64'd0);
        tick(); if_req = 0;
        smp();
        chk("mem_en_c1", 64'(mem_en), 64'd1);
        chk("mem_addr_c1", 64'(mem_addr), 64'h10);
        chk("mem_we_c1", 64'(mem_we), 64'd0);
        chk("mem_bmask_c1", 64'(mem_bmask), 64'hF);
        chk("busy_c1", 64'(busy), 64'd1);
        tick(); smp();
        chk("mem_en_c2", 64'(mem_en), 64'd0);
        chk("if_rvalid_c2", 64'(if_rvalid), 64'd0);
        tick(); smp();
        chk("if_rvalid_c3", 64'(if_rvalid), 64'd1);
        chk("if_rdata_c3", 64'(if_rdata), 64'h13);
        chk("ls_rvalid_c3", 64'(ls_rvalid), 64'd0);
        tick(); smp();
        chk("busy_c4", 64'(busy), 64'd0);
        chk("if_rvalid_c4", 64'(if_rvalid), 64'd0);

        // LS store
        tick(); ls_req = 1; ls_we = 1; ls_addr = 32'h7000; ls_wdata = 32'hDEADBEEF; ls_bmask = 4'b0011;
        smp();
        chk("st_gnt", 64'(ls_gnt), 64'd1);
        tick(); ls_req = 0; ls_we = 0;
        smp();
        chk("st_mem_en", 64'(mem_en), 64'd1);
        chk("st_mem_we", 64'(mem_we), 64'd1);
        chk("st_mem_addr", 64'(mem_addr), 64'h7000);
        chk("st_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("st_mem_bmask", 64'(mem_bmask), 64'h3);
        tick(); smp();
        chk("st_mem_en_off", 64'(mem_en), 64'd0);
        tick(); smp();
        chk("st_rvalid", 64'(ls_rvalid), 64'd1);
        chk("st_rdata", 64'(ls_rdata), 64'd0);
        chk("st_if_rvalid", 64'(if_rvalid), 64'd0);
        tick();

        // Simultaneous requests: LS first, IF in the next IDLE cycle
        tick(); ls_req = 1; ls_addr = 32'h100; if_req = 1; if_addr = 32'h200;
        smp();
        chk("sim_ls_gnt", 64'(ls_gnt), 64'd1);
        chk("sim_if_gnt0", 64'(if_gnt), 64'd0);
        tick(); ls_req = 0;
        smp();
        chk("sim_if_gnt1", 64'(if_gnt), 64'd0);
        tick(); tick(); smp();
        chk("sim_ls_rvalid", 64'(ls_rvalid), 64'd1);
        chk("sim_ls_rdata", 64'(ls_rdata), 64'h103);
        chk("sim_if_rvalid3", 64'(if_rvalid), 64'd0);
        chk("sim_if_rdata3", 64'(if_rdata), 64'd0);
        tick(); smp();
        chk("sim_if_gnt4", 64'(if_gnt), 64'd1);
        tick(); if_req = 0;
        smp();
        chk("sim_mem_addr5", 64'(mem_addr), 64'h200);
        tick(); tick(); smp();
        chk("sim_if_rvalid7", 64'(if_rvalid), 64'd1);
        chk("sim_if_rdata7", 64'(if_rdata), 64'h203);
        chk("sim_ls_rvalid7", 64'(ls_rvalid), 64'd0);
        chk("sim_ls_rdata7", 64'(ls_rdata), 64'd0);
        tick();
        wait_idle("sim_idle");

        // Continuous LS with IF pending
        ls_req = 1; ls_we = 0; ls_addr = 32'h400; if_req = 1; if_addr = 32'h500;
        ls_cnt = 0; if_cnt = 0; ls_before_if = -1;
        for (int c = 0; c < 80; c++) begin
            smp();
            if (if_gnt) begin
                if (if_cnt == 0) ls_before_if = ls_cnt;
                if_cnt++;
            end
            if (ls_gnt) ls_cnt++;
            tick();
        end
        ls_req = 0; if_req = 0;
`ifdef MEM_ARB_FAIRNESS_EN
        chk("fair_ls_before_if", 64'(ls_before_if), 64'd4);
`else
        chk("strict_if_grants", 64'(if_cnt), 64'd0);
        chk("strict_ls_grants", 64'(ls_cnt), 64'd20);
`endif
        wait_idle("starve_idle");

        // Reset during WAIT of an LS load
        tick(); ls_req = 1; ls_addr = 32'h300;
        smp();
        chk("rw_ls_gnt", 64'(ls_gnt), 64'd1);
        tick(); ls_req = 0;
        tick(); smp();
        chk("rw_busy_wait", 64'(busy), 64'd1);
        rst = 0;
        #1;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_mem_en", 64'(mem_en), 64'd0);
        chk("rw_mem_addr", 64'(mem_addr), 64'd0);
        chk("rw_ls_out", 64'({ls_gnt, ls_rvalid, ls_rdata}), 64'd0);
        for (int c = 0; c < 2; c++) begin
            tick(); smp();
            chk("rw_no_rvalid", 64'(ls_rvalid), 64'd0);
        end
        tick(); rst = 1;
        tick(); if_req = 1; if_addr = 32'h40;
        smp();
        chk("rw_if_gnt", 64'(if_gnt), 64'd1);
        tick(); if_req = 0;
        tick(); tick(); smp();
        chk("rw_if_rvalid", 64'(if_rvalid), 64'd1);
        chk("rw_if_rdata", 64'(if_rdata), 64'h43);
        tick();

        // MEM_LAT=1 instance: back-to-back fetches every 3 cycles
        tick(); if1_req = 1; if1_addr = addrs[0];
        for (int c = 0; c < 9; c++) begin
            smp();
            chk("l1_gnt", 64'(if1_gnt), 64'((c % 3) == 0));
            chk("l1_rvalid", 64'(if1_rvalid), 64'((c % 3) == 2));
            if ((c % 3) == 2) chk("l1_rdata", 64'(if1_rdata), 64'(addrs[c / 3] + 32'd3));
            tick();
            if ((c % 3) == 0) begin
                if (c < 6) if1_addr = addrs[c / 3 + 1];
                else if1_req = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
